// File: rtl/fetch_stage_pkg.sv
// Shared scalar types and fetch-stage constants: reset PC and the fetch FSM encoding.
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
endpackage

package pipes;
  import common::*;

  localparam u64 PCINIT = 64'h0000_0000_8000_0000;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    FETCH   = S_FETCH,
    HOLD    = S_HOLD,
    DISCARD = S_DISCARD
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-bus request/response bundle between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
  import common::*;

  logic ireq_valid;
  u64   ireq_addr;
  logic iresp_data_ok;
  u32   iresp_data;

  modport master (output ireq_valid, ireq_addr, input iresp_data_ok, iresp_data);
  modport slave  (input ireq_valid, ireq_addr, output iresp_data_ok, iresp_data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding bus request, a one-entry skid buffer for decode
// back-pressure, and redirect handling that drains a wrong-path request before refetching.
module fetch_stage
  import common::*;
#(
  parameter u64 PCINIT = pipes::PCINIT
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        ibus,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  u64                   redirect_pc,
  output logic                 f_valid,
  output u64                   f_pc,
  output u32                   f_raw_instr
);

  pipes::fetch_state_t r_state, w_state_next;
  u64   r_pc, w_pc_next;
  u64   r_npc, w_npc_next;
  u64   r_buf_pc, w_buf_pc_next;
  u32   r_buf_instr, w_buf_instr_next;
  logic r_f_valid, w_f_valid_next;
  u64   r_f_pc, w_f_pc_next;
  u32   r_f_instr, w_f_instr_next;
  logic w_load;
  logic w_slot_free;

  assign ibus.ireq_valid = (r_state == pipes::FETCH) || (r_state == pipes::DISCARD);
  assign ibus.ireq_addr  = r_pc;
  assign f_valid         = r_f_valid;
  assign f_pc            = r_f_pc;
  assign f_raw_instr     = r_f_instr;
  assign w_slot_free     = !r_f_valid || !stall;

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_npc_next       = r_npc;
    w_buf_pc_next    = r_buf_pc;
    w_buf_instr_next = r_buf_instr;
    w_f_pc_next      = r_f_pc;
    w_f_instr_next   = r_f_instr;
    w_load           = 1'b0;

    case (r_state)
      pipes::IDLE: w_state_next = pipes::FETCH;
      pipes::FETCH: begin
        if (redirect_valid) begin
          if (ibus.iresp_data_ok) begin
            w_pc_next = redirect_pc;
          end else begin
            w_npc_next   = redirect_pc;
            w_state_next = pipes::DISCARD;
          end
        end else if (ibus.iresp_data_ok) begin
          w_pc_next = r_pc + 64'd4;
          if (w_slot_free) begin
            w_load         = 1'b1;
            w_f_pc_next    = r_pc;
            w_f_instr_next = ibus.iresp_data;
          end else begin
            w_buf_pc_next    = r_pc;
            w_buf_instr_next = ibus.iresp_data;
            w_state_next     = pipes::HOLD;
          end
        end
      end
      // The buffer is only ever occupied while in HOLD, so the state doubles as its valid bit.
      pipes::HOLD: begin
        if (redirect_valid) begin
          w_pc_next    = redirect_pc;
          w_state_next = pipes::FETCH;
        end else if (!stall) begin
          w_load         = 1'b1;
          w_f_pc_next    = r_buf_pc;
          w_f_instr_next = r_buf_instr;
          w_state_next   = pipes::FETCH;
        end
      end
      pipes::DISCARD: begin
        if (redirect_valid) begin
          if (ibus.iresp_data_ok) begin
            w_pc_next    = redirect_pc;
            w_state_next = pipes::FETCH;
          end else begin
            w_npc_next = redirect_pc;
          end
        end else if (ibus.iresp_data_ok) begin
          w_pc_next    = r_npc;
          w_state_next = pipes::FETCH;
        end
      end
      default: w_state_next = pipes::IDLE;
    endcase

    // A redirect flushes whatever decode holds, even if it is stalled.
    if (redirect_valid)  w_f_valid_next = 1'b0;
    else if (w_load)     w_f_valid_next = 1'b1;
    else if (!stall)     w_f_valid_next = 1'b0;
    else                 w_f_valid_next = r_f_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= pipes::IDLE;
      r_pc        <= PCINIT;
      r_npc       <= PCINIT;
      r_buf_pc    <= '0;
      r_buf_instr <= '0;
      r_f_valid   <= 1'b0;
      r_f_pc      <= '0;
      r_f_instr   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_npc       <= w_npc_next;
      r_buf_pc    <= w_buf_pc_next;
      r_buf_instr <= w_buf_instr_next;
      r_f_valid   <= w_f_valid_next;
      r_f_pc      <= w_f_pc_next;
      r_f_instr   <= w_f_instr_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch-stage bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based delivery model.
module tb_fetch_stage;
  import common::*;

  localparam u64 PCI = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic redirect_valid = 1'b0;
  u64   redirect_pc = '0;
  logic f_valid;
  u64   f_pc;
  u32   f_raw_instr;

  fetch_stage_if bus ();

  fetch_stage #(.PCINIT(PCI)) dut (
    .clk            (clk),
    .reset          (reset),
    .ibus           (bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_raw_instr    (f_raw_instr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input u64 act, input u64 exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the presented instruction is the head of a delivery queue (at most two entries:
  // the decode slot plus one spare). Fetching pauses while the queue is full. After a redirect
  // with a request still in flight, that request's data is thrown away before the target is used.
  u64  m_pc;
  u64  m_tgt;
  bit  m_wrong;
  bit  m_started;
  bit  m_active;
  bit  model_on = 1'b0;
  u64  q_pc[$];
  u32  q_dat[$];

  always @(posedge clk) begin
    if (reset) begin
      m_pc      = PCI;
      m_tgt     = PCI;
      m_wrong   = 1'b0;
      m_started = 1'b0;
      q_pc.delete();
      q_dat.delete();
      model_on  = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else begin
      m_active = (q_pc.size() < 2);
      if (redirect_valid) begin
        q_pc.delete();
        q_dat.delete();
        if (m_active && !bus.iresp_data_ok) begin
          m_wrong = 1'b1;
          m_tgt   = redirect_pc;
        end else begin
          m_wrong = 1'b0;
          m_pc    = redirect_pc;
        end
      end else begin
        if (!stall && q_pc.size() > 0) begin
          void'(q_pc.pop_front());
          void'(q_dat.pop_front());
        end
        if (m_active && bus.iresp_data_ok) begin
          if (m_wrong) begin
            m_wrong = 1'b0;
            m_pc    = m_tgt;
          end else begin
            q_pc.push_back(m_pc);
            q_dat.push_back(bus.iresp_data);
            m_pc = m_pc + 64'd4;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_ireq_valid", bus.ireq_valid, u64'(m_started && q_pc.size() < 2));
      if (m_started && q_pc.size() < 2) chk("m_ireq_addr", bus.ireq_addr, m_pc);
      chk("m_f_valid", f_valid, u64'(q_pc.size() > 0));
      if (q_pc.size() > 0) begin
        chk("m_f_pc", f_pc, q_pc[0]);
        chk("m_f_raw_instr", f_raw_instr, u64'(q_dat[0]));
      end
    end
  end

  task automatic drive(input bit rst, input bit stl, input bit dok, input u32 dat,
                       input bit rv, input u64 rpc);
    @(posedge clk);
    #1;
    reset              = rst;
    stall              = stl;
    bus.iresp_data_ok  = dok;
    bus.iresp_data     = dat;
    redirect_valid     = rv;
    redirect_pc        = rpc;
  endtask

  initial begin
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = '0;

    drive(1, 0, 0, 32'h0, 0, 64'h0);
    drive(0, 0, 1, 32'h13, 0, 64'h0);
    chk("rst_ireq_valid", bus.ireq_valid, 0);
    chk("rst_f_valid", f_valid, 0);
    chk("rst_f_pc", f_pc, 0);
    chk("rst_f_raw", f_raw_instr, 0);

    // Back-to-back stream
    drive(0, 0, 1, 32'h13, 0, 64'h0);
    chk("stream_addr0", bus.ireq_addr, 64'h8000_0000);
    chk("stream_fv0", f_valid, 0);
    drive(0, 0, 1, 32'h13, 0, 64'h0);
    chk("stream_fv1", f_valid, 1);
    chk("stream_fpc1", f_pc, 64'h8000_0000);
    chk("stream_raw1", f_raw_instr, 32'h13);
    chk("stream_addr1", bus.ireq_addr, 64'h8000_0004);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    chk("stream_fpc2", f_pc, 64'h8000_0004);
    chk("stream_addr2", bus.ireq_addr, 64'h8000_0008);

    // Three-cycle bus latency
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    chk("lat_fv_gap", f_valid, 0);
    chk("lat_addr_hold1", bus.ireq_addr, 64'h8000_0008);
    drive(0, 0, 1, 32'hAAAA_0008, 0, 64'h0);
    chk("lat_addr_hold2", bus.ireq_addr, 64'h8000_0008);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    chk("lat_fv", f_valid, 1);
    chk("lat_fpc", f_pc, 64'h8000_0008);
    chk("lat_raw", f_raw_instr, 32'hAAAA_0008);
    chk("lat_addr_next", bus.ireq_addr, 64'h8000_000C);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    chk("lat_single_pulse", f_valid, 0);

    // Stall with one extra fetch buffered
    drive(0, 0, 1, 32'hD00C, 0, 64'h0);
    drive(0, 1, 1, 32'hD010, 0, 64'h0);
    chk("stall_fpc0", f_pc, 64'h8000_000C);
    drive(0, 1, 1, 32'hDEAD, 0, 64'h0);
    chk("stall_hold_noreq", bus.ireq_valid, 0);
    chk("stall_frozen1", f_pc, 64'h8000_000C);
    drive(0, 1, 0, 32'h0, 0, 64'h0);
    chk("stall_frozen2", f_raw_instr, 32'hD00C);
    drive(0, 1, 0, 32'h0, 0, 64'h0);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    chk("stall_frozen_fv", f_valid, 1);
    chk("stall_frozen3", f_pc, 64'h8000_000C);
    drive(0, 0, 0, 32'h0, 1, 64'h8000_0100);
    chk("stall_second_pc", f_pc, 64'h8000_0010);
    chk("stall_second_raw", f_raw_instr, 32'hD010);
    chk("stall_resume_addr", bus.ireq_addr, 64'h8000_0014);

    // Redirect with the request still outstanding
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    chk("redir_fv_clear", f_valid, 0);
    chk("redir_addr_hold1", bus.ireq_addr, 64'h8000_0014);
    drive(0, 0, 1, 32'hBAD, 0, 64'h0);
    chk("redir_addr_hold2", bus.ireq_addr, 64'h8000_0014);
    drive(0, 0, 1, 32'h0100_0013, 0, 64'h0);
    chk("redir_new_addr", bus.ireq_addr, 64'h8000_0100);
    chk("redir_dropped", f_valid, 0);
    drive(0, 1, 1, 32'hBAD2, 1, 64'h8000_0200);
    chk("redir_target_fpc", f_pc, 64'h8000_0100);

    // Redirect and data in the same cycle under stall
    drive(0, 0, 0, 32'h0, 1, 64'h8000_0300);
    chk("same_fv_clear", f_valid, 0);
    chk("same_addr", bus.ireq_addr, 64'h8000_0200);

    // Reset while discarding
    drive(1, 0, 0, 32'h0, 0, 64'h0);
    chk("disc_addr", bus.ireq_addr, 64'h8000_0200);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    chk("disc_rst_noreq", bus.ireq_valid, 0);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    chk("disc_rst_addr", bus.ireq_addr, PCI);

    // Random traffic, including redirects near the top of the address space
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 400) == 0,
            ($urandom % 4) == 0,
            ($urandom % 3) != 0,
            $urandom,
            ($urandom % 12) == 0,
            (($urandom % 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom});
    end
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PCINIT, 64'h0000_0000_8000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ireq_valid  output  1  instruction-bus request valid.
REQ-005 ireq_addr  output  64  instruction-bus request address; equals current fetch PC.
REQ-006 iresp_data_ok  input  1  bus returns data for the outstanding request this cycle.
REQ-007 iresp_data  input  32  instruction word; valid only when iresp_data_ok=1.
REQ-008 stall  input  1  decode cannot accept a new instruction this cycle.
REQ-009 redirect_valid  input  1  branch/jump resolved taken; flush and refetch.
REQ-010 redirect_pc  input  64  redirect target; valid only when redirect_valid=1.
REQ-011 f_valid  output  1  registered: f_pc/f_raw_instr hold a live instruction for decode.
REQ-012 f_pc  output  64  registered PC of the presented instruction.
REQ-013 f_raw_instr  output  32  registered instruction word, drives the decoder's raw_instr.

Function
REQ-014 States: IDLE, FETCH, HOLD, DISCARD; ireq_valid=1 exactly in FETCH and DISCARD.
REQ-015 While ireq_valid=1, ireq_addr stays constant until the cycle iresp_data_ok=1.
REQ-016 IDLE -> FETCH unconditionally on the first non-reset cycle.
REQ-017 FETCH, data_ok=1, no redirect, output slot free (f_valid=0 or stall=0): load f_valid=1, f_pc=pc, f_raw_instr=iresp_data next cycle; pc<=pc+4; remain FETCH.
REQ-018 FETCH, data_ok=1, no redirect, slot occupied (f_valid=1 and stall=1): capture pc/data into one-entry buffer; pc<=pc+4; go HOLD.
REQ-019 HOLD: ireq_valid=0; when stall=0, move buffer into output registers, go FETCH.
REQ-020 FETCH, redirect_valid=1, data_ok=1 same cycle: drop data, pc<=redirect_pc, remain FETCH.
REQ-021 FETCH, redirect_valid=1, data_ok=0: npc<=redirect_pc, go DISCARD (ireq_addr unchanged).
REQ-022 DISCARD: on data_ok drop data, pc<=npc, go FETCH; a further redirect in DISCARD overwrites npc (same-cycle redirect+data_ok: pc<=redirect_pc).
REQ-023 HOLD, redirect_valid=1: discard buffer, pc<=redirect_pc, go FETCH.
REQ-024 Any redirect_valid=1 clears f_valid next cycle, overriding stall and any load.
REQ-025 No redirect, stall=0, f_valid=1, nothing to load: f_valid<=0 next cycle.
REQ-026 stall=1, f_valid=1, no redirect: f_valid/f_pc/f_raw_instr held unchanged.
REQ-027 Latency: data_ok in cycle t -> f_valid=1 in t+1; next request (pc+4) issued in t+1; sustained throughput 1 instr/cycle when data_ok same-cycle.
REQ-028 PC arithmetic 64-bit, +4 wraps modulo 2^64; no alignment check.

Reset
REQ-029 reset=1: state<=IDLE, pc<=PCINIT, npc<=PCINIT, buffer invalid, f_valid<=0, f_pc<=0, f_raw_instr<=0; ireq_valid=0 during and one cycle after reset.
REQ-030 Reset mid-transaction abandons the outstanding request; any data_ok in IDLE is ignored.

Structure
REQ-031 PCINIT and fetch_state_t enum in package pipes; u64/u32 from package common.
REQ-032 Single module, no sub-modules; buffer and output registers in one always_ff, next-state in one always_comb.

Verification
REQ-033 Reset release, data_ok=1 every cycle, data=0x00000013 -> ireq_addr 0x80000000,0x80000004,...; f_valid=1 from cycle after first data_ok, f_pc following by one cycle.
REQ-034 Bus latency 3 cycles -> ireq_addr held 0x80000000 for 3 cycles, single f_valid pulse with f_pc=0x80000000.
REQ-035 stall=1 for 4 cycles with f_valid=1 -> outputs frozen, one extra fetch buffered (HOLD, ireq_valid=0), both delivered in order after stall drops.
REQ-036 Redirect to 0x80000100 while request to 0x80000008 outstanding (data_ok 2 cycles later) -> ireq_addr stays 0x80000008 until data_ok, that data dropped, next ireq_addr=0x80000100, f_valid=0 meanwhile.
REQ-037 Redirect and data_ok same cycle, stall=1 -> f_valid=0 next cycle, next ireq_addr=redirect_pc, dropped word never appears.
REQ-038 Reset asserted in DISCARD -> IDLE, then ireq_addr=0x80000000.
